// File: rtl/poly_eval_seq_if.sv
// Load/result bus for poly_eval_seq: coefficient/x input with go strobe, result and status back.
interface poly_eval_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             go;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_result;
  logic             done;
  logic             busy;
  logic             ovf;

  modport master (
    output go,
    output data_in,
    input  data_result,
    input  done,
    input  busy,
    input  ovf
  );

  modport slave (
    input  go,
    input  data_in,
    output data_result,
    output done,
    output busy,
    output ovf
  );
endinterface

// File: rtl/poly_eval_seq.sv
// Sequential unsigned polynomial evaluator: loads DEGREE+1 coefficients then x, Horner on one ALU.
// Define POLY_EVAL_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module poly_eval_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEGREE = 2
) (
  input logic            clk,
  input logic            resetn,
  poly_eval_seq_if.slave bus
);

  localparam int unsigned IdxW = $clog2(DEGREE + 2);
  localparam int unsigned KW   = $clog2(DEGREE + 1);
`ifdef POLY_EVAL_OVF_EN
  localparam int unsigned ProdW = 2 * WIDTH;
  localparam int unsigned SumW  = WIDTH + 1;
`else
  localparam int unsigned ProdW = WIDTH;
  localparam int unsigned SumW  = WIDTH;
`endif

  typedef enum logic [2:0] {StLoad, StLoadWait, StInit, StMul, StAdd} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [KW-1:0]     k_q, k_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [WIDTH-1:0]  coef_q [DEGREE+1];
  logic [WIDTH-1:0]  coef_d [DEGREE+1];
  logic [WIDTH-1:0]  result_q, result_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic [WIDTH-1:0]  ck;
  logic [ProdW-1:0]  prod;
  logic [SumW-1:0]   sum;

  always_comb begin
    ck = '0;
    for (int i = 0; i <= int'(DEGREE); i++) begin
      if (k_q == KW'(i)) ck = coef_q[i];
    end
  end

  assign prod = acc_q * x_q;
  assign sum  = acc_q + ck;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    k_d      = k_q;
    acc_d    = acc_q;
    x_d      = x_q;
    coef_d   = coef_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      StLoad: begin
        // Load order runs from the leading coefficient down, x last.
        if (idx_q == IdxW'(DEGREE + 1)) begin
          x_d = bus.data_in;
        end else begin
          for (int i = 0; i <= int'(DEGREE); i++) begin
            if (idx_q == IdxW'(int'(DEGREE) - i)) coef_d[i] = bus.data_in;
          end
        end
        if (bus.go) state_d = StLoadWait;
      end
      StLoadWait: begin
        if (!bus.go) begin
          if (idx_q == IdxW'(DEGREE + 1)) begin
            idx_d   = '0;
            state_d = StInit;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StLoad;
          end
        end
      end
      StInit: begin
        acc_d   = coef_q[DEGREE];
        k_d     = KW'(DEGREE - 1);
        state_d = StMul;
      end
      StMul: begin
        acc_d   = prod[WIDTH-1:0];
        state_d = StAdd;
      end
      StAdd: begin
        if (k_q == '0) begin
          result_d = sum[WIDTH-1:0];
          done_d   = 1'b1;
          state_d  = StLoad;
        end else begin
          acc_d   = sum[WIDTH-1:0];
          k_d     = k_q - 1'b1;
          state_d = StMul;
        end
      end
      default: state_d = StLoad;
    endcase
    busy_d = (state_d == StInit) || (state_d == StMul) || (state_d == StAdd);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StLoad;
      idx_q    <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      x_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      for (int i = 0; i <= int'(DEGREE); i++) coef_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      x_q      <= x_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      coef_q   <= coef_d;
    end
  end

  assign bus.data_result = result_q;
  assign bus.done        = done_q;
  assign bus.busy        = busy_q;

`ifdef POLY_EVAL_OVF_EN
  logic flag_q, flag_d;
  logic ovf_q, ovf_d;

  always_comb begin
    flag_d = flag_q;
    ovf_d  = ovf_q;
    unique case (state_q)
      StInit: flag_d = 1'b0;
      StMul:  flag_d = flag_q | (|prod[ProdW-1:WIDTH]);
      StAdd: begin
        flag_d = flag_q | sum[WIDTH];
        if (k_q == '0) ovf_d = flag_q | sum[WIDTH];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flag_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      flag_q <= flag_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_poly_eval_seq.sv
// Directed bench for poly_eval_seq: three instances (8b/deg2, 8b/deg3, 16b/deg1), table + sequences.
module tb_poly_eval_seq;

`ifdef POLY_EVAL_OVF_EN
  localparam bit OvfEn = 1'b1;
`else
  localparam bit OvfEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  poly_eval_seq_if #(.WIDTH(8))  if0 ();
  poly_eval_seq_if #(.WIDTH(8))  if1 ();
  poly_eval_seq_if #(.WIDTH(16)) if2 ();

  poly_eval_seq #(.WIDTH(8),  .DEGREE(2)) u_d0 (.clk(clk), .resetn(resetn), .bus(if0));
  poly_eval_seq #(.WIDTH(8),  .DEGREE(3)) u_d1 (.clk(clk), .resetn(resetn), .bus(if1));
  poly_eval_seq #(.WIDTH(16), .DEGREE(1)) u_d2 (.clk(clk), .resetn(resetn), .bus(if2));

  logic        go_r  [3];
  logic [15:0] din_r [3];
  logic [15:0] res   [3];
  logic        done_v[3];
  logic        busy_v[3];
  logic        ovf_v [3];

  assign if0.go = go_r[0];
  assign if1.go = go_r[1];
  assign if2.go = go_r[2];
  assign if0.data_in = din_r[0][7:0];
  assign if1.data_in = din_r[1][7:0];
  assign if2.data_in = din_r[2];
  assign res[0] = {8'h00, if0.data_result};
  assign res[1] = {8'h00, if1.data_result};
  assign res[2] = if2.data_result;
  assign done_v[0] = if0.done;
  assign done_v[1] = if1.done;
  assign done_v[2] = if2.done;
  assign busy_v[0] = if0.busy;
  assign busy_v[1] = if1.busy;
  assign busy_v[2] = if2.busy;
  assign ovf_v[0] = if0.ovf;
  assign ovf_v[1] = if1.ovf;
  assign ovf_v[2] = if2.ovf;

  typedef struct packed {
    int               u;
    logic [7:0][15:0] v;
    logic [15:0]      res;
    logic             ovf;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(input int u, input logic [15:0] a0, input logic [15:0] a1,
                              input logic [15:0] a2, input logic [15:0] a3,
                              input logic [15:0] a4, input logic [15:0] r, input logic o);
    vec_t t;
    t.u    = u;
    t.v    = '0;
    t.v[0] = a0;
    t.v[1] = a1;
    t.v[2] = a2;
    t.v[3] = a3;
    t.v[4] = a4;
    t.res  = r;
    t.ovf  = o;
    return t;
  endfunction

  function automatic int deg_of(input int u);
    return (u == 0) ? 2 : ((u == 1) ? 3 : 1);
  endfunction

  function automatic logic eo(input logic o);
    return OvfEn & o;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic press(input int u, input logic [15:0] v);
    @(negedge clk);
    din_r[u] = v;
    go_r[u]  = 1'b1;
    @(negedge clk);
    go_r[u]  = 1'b0;
  endtask

  // Called right after the x press: counts cycles to done and busy cycles before it.
  task automatic run_eval(input int u, input string name, input logic [15:0] exp_res,
                          input logic exp_ovf);
    int n;
    int busy_n;
    int d;
    bit seen;
    n      = 0;
    busy_n = 0;
    seen   = 1'b0;
    d      = deg_of(u);
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (done_v[u]) seen = 1'b1;
      else if (busy_v[u]) busy_n++;
    end
    check({name, " done"}, 16'(seen), 16'd1);
    check({name, " latency"}, 16'(n), 16'(2 * d + 2));
    check({name, " busy cycles"}, 16'(busy_n), 16'(2 * d + 1));
    check({name, " busy at done"}, 16'(busy_v[u]), 16'd0);
    check({name, " result"}, res[u], exp_res);
    check({name, " ovf"}, 16'(ovf_v[u]), 16'(exp_ovf));
    @(negedge clk);
    check({name, " done clears"}, 16'(done_v[u]), 16'd0);
    check({name, " result holds"}, res[u], exp_res);
  endtask

  initial begin
    int d;
    int pulses;
    vecs[0] = mk(0, 16'd3, 16'd2, 16'd1, 16'd4, 16'd0, 16'd57, 1'b0);
    vecs[1] = mk(0, 16'd16, 16'd0, 16'd0, 16'd16, 16'd0, 16'd0, 1'b1);
    vecs[2] = mk(0, 16'd1, 16'd1, 16'd1, 16'd2, 16'd0, 16'd7, 1'b0);
    vecs[3] = mk(1, 16'd1, 16'd0, 16'd0, 16'd5, 16'd3, 16'd32, 1'b0);
    vecs[4] = mk(2, 16'h0100, 16'h0001, 16'h0100, 16'd0, 16'd0, 16'h0001, 1'b1);
    vecs[5] = mk(0, 16'd255, 16'd255, 16'd255, 16'd1, 16'd0, 16'd253, 1'b1);
    vecs[6] = mk(0, 16'd0, 16'd1, 16'd255, 16'd1, 16'd0, 16'd0, 1'b1);
    vecs[7] = mk(0, 16'd0, 16'd0, 16'd200, 16'd0, 16'd0, 16'd200, 1'b0);
    vecs[8] = mk(1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd2, 16'd41, 1'b0);
    vecs[9] = mk(2, 16'h1234, 16'h0005, 16'h0002, 16'd0, 16'd0, 16'h246D, 1'b0);

    resetn = 1'b0;
    for (int u = 0; u < 3; u++) begin
      go_r[u]  = 1'b0;
      din_r[u] = 16'd0;
    end
    #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("reset result u%0d", u), res[u], 16'd0);
      check($sformatf("reset done u%0d", u), 16'(done_v[u]), 16'd0);
      check($sformatf("reset busy u%0d", u), 16'(busy_v[u]), 16'd0);
      check($sformatf("reset ovf u%0d", u), 16'(ovf_v[u]), 16'd0);
    end
    @(negedge clk);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      d = deg_of(vecs[i].u);
      for (int j = 0; j <= d + 1; j++) press(vecs[i].u, vecs[i].v[j]);
      run_eval(vecs[i].u, $sformatf("vec%0d", i), vecs[i].res, eo(vecs[i].ovf));
    end

    // Long go hold on c[2]: value changes during the hold must not be captured.
    @(negedge clk);
    din_r[0] = 16'd9;
    go_r[0]  = 1'b1;
    @(negedge clk);
    din_r[0] = 16'd77;
    repeat (49) @(negedge clk);
    check("hold busy", 16'(busy_v[0]), 16'd0);
    go_r[0] = 1'b0;
    press(0, 16'd0);
    press(0, 16'd0);
    press(0, 16'd2);
    run_eval(0, "hold", 16'd36, 1'b0);

    // go toggling while busy is ignored.
    press(0, 16'd3);
    press(0, 16'd2);
    press(0, 16'd1);
    press(0, 16'd4);
    fork
      run_eval(0, "toggle", 16'd57, 1'b0);
      begin
        repeat (4) begin
          @(negedge clk);
          go_r[0]  = ~go_r[0];
          din_r[0] = 16'h00AA;
        end
        go_r[0] = 1'b0;
      end
    join
    press(0, 16'd1);
    press(0, 16'd1);
    press(0, 16'd1);
    press(0, 16'd2);
    run_eval(0, "after toggle", 16'd7, 1'b0);

    // Asynchronous reset in the middle of S_MUL.
    press(0, 16'd3);
    press(0, 16'd2);
    press(0, 16'd1);
    press(0, 16'd4);
    @(negedge clk);
    @(negedge clk);
    check("pre-reset busy", 16'(busy_v[0]), 16'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("async reset result", res[0], 16'd0);
    check("async reset busy", 16'(busy_v[0]), 16'd0);
    check("async reset done", 16'(done_v[0]), 16'd0);
    check("async reset ovf", 16'(ovf_v[0]), 16'd0);
    check("async reset result u2", res[2], 16'd0);
    @(negedge clk);
    resetn = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_v[0] || busy_v[0]) pulses++;
    end
    check("no activity after reset", 16'(pulses), 16'd0);
    press(0, 16'd1);
    press(0, 16'd1);
    press(0, 16'd1);
    press(0, 16'd2);
    run_eval(0, "reload", 16'd7, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/poly_eval_seq.md
# poly_eval_seq

Parametrised sequential unsigned polynomial evaluator, the successor to the fixed quadratic FSM/datapath pair. It loads DEGREE+1 coefficients and then x through the shared `data_in` bus, one go press per value. It then evaluates p(x) = c[DEGREE]·x^DEGREE + … + c[0] by Horner's rule on a single time-shared multiply/add ALU. It sits under fpga_top in place of the fixed-degree part, feeding LEDR and the hex decoders.

## Interface
- WIDTH, 8: data/coefficient/result width in bits, 2..16.
- DEGREE, 2: polynomial degree, 1..7; DEGREE+1 coefficients are stored.
- clk  input  1  system clock; all state on rising edge.
- resetn  input  1  asynchronous active-low reset.
- go  input  1  level-sensitive load strobe, active high (already inverted from KEY).
- data_in  input  WIDTH  coefficient / x value.
- data_result  output  WIDTH  last result, mod 2^WIDTH; reset 0.
- done  output  1  one-cycle pulse when data_result updates; reset 0.
- busy  output  1  high while evaluating; reset 0.
- ovf  output  1  overflow flag for last result (see Configuration); reset 0.

## Operation
- Storage: coef[0..DEGREE], x, acc (all WIDTH bits); load index idx (0..DEGREE+1); Horner index k.
- Load order: idx 0 → c[DEGREE], idx 1 → c[DEGREE-1], …, idx DEGREE → c[0], idx DEGREE+1 → x.
- States:
  - S_LOAD: target register captures data_in every cycle. go=1 → S_LOAD_WAIT (value on that edge is the loaded value).
  - S_LOAD_WAIT: no capture. Stay while go=1. On go=0: if idx==DEGREE+1 → S_INIT, idx←0; else idx←idx+1 → S_LOAD.
  - S_INIT: acc←c[DEGREE], k←DEGREE-1, ovf accumulator cleared → S_MUL.
  - S_MUL: acc←(acc·x)[WIDTH-1:0] → S_ADD.
  - S_ADD: sum = acc+c[k]. If k==0: data_result←sum[WIDTH-1:0], done←1, ovf output updated → S_LOAD. Else acc←sum, k←k-1 → S_MUL.
- All arithmetic unsigned; truncation to WIDTH bits after every operation.
- busy=1 in S_INIT, S_MUL, S_ADD. go is ignored while busy; a go held high through the end of evaluation is treated as a new press on re-entering S_LOAD.
- data_result and ovf hold until the next completed evaluation. Coefficients and x are retained and overwritten only by the next load sequence.
- resetn low at any time: state→S_LOAD, idx/k/acc/coef/x/data_result/done/busy/ovf all 0, immediately and asynchronously. A partial load or evaluation is discarded.

## Timing
- One register load per press: minimum two cycles (S_LOAD with go=1, S_LOAD_WAIT with go=0).
- Evaluation latency: the edge that leaves S_LOAD_WAIT for x is edge E0. done is high in the cycle after edge E0+1+2·DEGREE; for DEGREE=2, that is 5 edges after E0.
- done is high exactly one cycle and is cleared on the next edge.
- data_result changes only on the done-setting edge.
- busy falls on the same edge that sets done.
- ALU path is a single WIDTH×WIDTH multiply or WIDTH add per cycle, never both.

## Configuration
- POLY_EVAL_OVF_EN defined:
  - An internal sticky flag sets when any S_MUL full product ≥ 2^WIDTH or any S_ADD carry-out occurs.
  - The flag clears in S_INIT.
  - ovf←flag on the done edge, including overflow from the final add.
- Undefined: ovf tied to 0, with no overflow logic synthesised; port still present.

## Test plan
- WIDTH=8, DEGREE=2: load 3, 2, 1, x=4 → done after 5 edges, data_result=0x39 (57), ovf=0, busy high 5 cycles.
- WIDTH=8, DEGREE=2, OVF_EN: load 16, 0, 0, x=16 → data_result=0x00, ovf=1. Next run 1, 1, 1, x=2 → 0x07, ovf=0.
- WIDTH=8, DEGREE=3: load 1, 0, 0, 5, x=3 → data_result=0x20 (32), done at E0+7.
- Hold go high 50 cycles on c[DEGREE] load, then release → only idx advances by one. Toggle go during busy → no register changes, result unchanged.
- Assert resetn low mid-S_MUL (asynchronous, between edges) → all outputs 0 immediately, no done pulse. After release, a full reload gives the correct result.
- WIDTH=16, DEGREE=1: load 0x0100, 0x0001, x=0x0100 → data_result=0x0001 (wrap), ovf=1 with OVF_EN.
